// File: rtl/accbank_defs.sv
// Shared definitions for the accumulator bank: opcodes, FSM states and flag payload.
package accbank_defs;

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_LOAD_IN = 3'b001;
  localparam logic [2:0] OP_LOAD_IR = 3'b010;
  localparam logic [2:0] OP_CLR     = 3'b011;
  localparam logic [2:0] OP_ADD     = 3'b100;
  localparam logic [2:0] OP_SUB     = 3'b101;
  localparam logic [2:0] OP_SHR     = 3'b110;
  localparam logic [2:0] OP_MUL     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_MULT  = 2'b01,
    ST_WRITE = 2'b10
  } state_e;

  typedef struct packed {
    logic carry;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/accumulator_bank_if.sv
// Request/response bundle between the control path and the accumulator bank.
interface accumulator_bank_if #(
  parameter int unsigned N    = 8,
  parameter int unsigned NREG = 4
);
  localparam int unsigned SELW = $clog2(NREG);

  logic [N-1:0]    IROut;
  logic [N-1:0]    Input;
  logic [2:0]      op;
  logic [SELW-1:0] regSel;
  logic            start;
  logic            busy;
  logic            done;
  logic [N-1:0]    regAOut;
  logic            Aeq0;
  logic            Apos;
  logic            carry;
  logic            ovf;

  modport master (
    output IROut, Input, op, regSel, start,
    input  busy, done, regAOut, Aeq0, Apos, carry, ovf
  );

  modport slave (
    input  IROut, Input, op, regSel, start,
    output busy, done, regAOut, Aeq0, Apos, carry, ovf
  );
endinterface

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier: one partial product per clock, N clocks per product.
// product reflects the current iteration, so it is final while last is high.
module seq_multiplier #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           clearN,
  input  logic           go,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] product,
  output logic           busy,
  output logic           last
);
  localparam int unsigned CW = $clog2(N);

  logic [2*N-1:0] r_a;
  logic [N-1:0]   r_b;
  logic [2*N-1:0] r_prod;
  logic [CW-1:0]  r_cnt;
  logic           r_busy;
  logic [2*N-1:0] w_prod_nxt;

  assign w_prod_nxt = r_prod + (r_b[0] ? r_a : '0);
  assign product    = w_prod_nxt;
  assign busy       = r_busy;
  assign last       = r_busy && (r_cnt == CW'(N-1));

  always_ff @(posedge clk or negedge clearN) begin
    if (!clearN) begin
      r_a    <= '0;
      r_b    <= '0;
      r_prod <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (go && !r_busy) begin
      r_a    <= {N'(0), a};
      r_b    <= b;
      r_prod <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_prod <= w_prod_nxt;
      r_a    <= r_a << 1;
      r_b    <= r_b >> 1;
      r_cnt  <= r_cnt + CW'(1);
      if (last) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/accumulator_bank.sv
// Bank of NREG accumulators with a single-cycle ALU, condition flags and a
// sequential multiply path that shares the register write port.
module accumulator_bank
  import accbank_defs::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned NREG = 4
) (
  input logic               clk,
  input logic               clearN,
  accumulator_bank_if.slave bus
);
  localparam int unsigned SELW = $clog2(NREG);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [N-1:0]    r_acc [NREG];
  logic [SELW-1:0] r_tgt;
  flags_t          r_flags;
  logic            r_done;

  logic            w_accept;
  logic            w_go;
  logic            w_mul_busy;
  logic            w_mul_last;
  logic [2*N-1:0]  w_prod;
  logic [N-1:0]    w_a;
  logic [N:0]      w_sum;
  logic [N:0]      w_diff;
  logic [N-1:0]    w_alu;
  flags_t          w_alu_flags;
  logic            w_alu_wr;
  logic            w_alu_fupd;

  assign w_a      = r_acc[bus.regSel];
  assign w_accept = bus.start && (r_state != ST_MULT);
  assign w_go     = w_accept && (bus.op == OP_MUL) && !w_mul_busy;
  assign w_sum    = {1'b0, w_a} + {1'b0, bus.IROut};
  assign w_diff   = {1'b0, w_a} - {1'b0, bus.IROut};

  assign bus.regAOut = w_a;
  assign bus.Aeq0    = (w_a == '0);
  assign bus.Apos    = ~w_a[N-1];
  assign bus.busy    = (r_state == ST_MULT);
  assign bus.done    = r_done;
  assign bus.carry   = r_flags.carry;
  assign bus.ovf     = r_flags.ovf;

  seq_multiplier #(.N(N)) u_mul (
    .clk     (clk),
    .clearN  (clearN),
    .go      (w_go),
    .a       (w_a),
    .b       (bus.IROut),
    .product (w_prod),
    .busy    (w_mul_busy),
    .last    (w_mul_last)
  );

  // Single-cycle ALU result and flag candidates for the selected accumulator
  always_comb begin
    w_alu       = w_a;
    w_alu_flags = r_flags;
    w_alu_wr    = 1'b0;
    w_alu_fupd  = 1'b0;
    case (bus.op)
      OP_LOAD_IN: begin
        w_alu    = bus.Input;
        w_alu_wr = 1'b1;
      end
      OP_LOAD_IR: begin
        w_alu    = bus.IROut;
        w_alu_wr = 1'b1;
      end
      OP_CLR: begin
        w_alu    = '0;
        w_alu_wr = 1'b1;
      end
      OP_ADD: begin
        w_alu             = w_sum[N-1:0];
        w_alu_wr          = 1'b1;
        w_alu_fupd        = 1'b1;
        w_alu_flags.carry = w_sum[N];
        w_alu_flags.ovf   = (w_a[N-1] == bus.IROut[N-1]) && (w_sum[N-1] != w_a[N-1]);
      end
      OP_SUB: begin
        w_alu             = w_diff[N-1:0];
        w_alu_wr          = 1'b1;
        w_alu_fupd        = 1'b1;
        w_alu_flags.carry = ~w_diff[N];
        w_alu_flags.ovf   = (w_a[N-1] != bus.IROut[N-1]) && (w_diff[N-1] != w_a[N-1]);
      end
      OP_SHR: begin
        w_alu             = {w_a[N-1], w_a[N-1:1]};
        w_alu_wr          = 1'b1;
        w_alu_fupd        = 1'b1;
        w_alu_flags.carry = w_a[0];
        w_alu_flags.ovf   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clearN) begin
    if (!clearN) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // WRITE is the done cycle of a multiply and may accept the next request
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_go) w_state_nxt = ST_MULT;
      ST_MULT:  if (w_mul_last) w_state_nxt = ST_WRITE;
      ST_WRITE: w_state_nxt = w_go ? ST_MULT : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Write port: multiply completion and ALU writes never coincide (accept needs !busy)
  always_ff @(posedge clk or negedge clearN) begin
    if (!clearN) begin
      for (int i = 0; i < NREG; i++) r_acc[i] <= '0;
      r_tgt   <= '0;
      r_flags <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_mul_last) begin
        r_acc[r_tgt]  <= w_prod[N-1:0];
        r_flags.carry <= |w_prod[2*N-1:N];
        r_flags.ovf   <= 1'b0;
        r_done        <= 1'b1;
      end else if (w_accept && w_alu_wr) begin
        r_acc[bus.regSel] <= w_alu;
        if (w_alu_fupd) r_flags <= w_alu_flags;
        r_done <= 1'b1;
      end
      if (w_go) r_tgt <= bus.regSel;
    end
  end

endmodule

// File: tb/tb_accumulator_bank.sv
// Scoreboard bench for accumulator_bank (N=8, NREG=4) with directed vectors.
module tb_accumulator_bank;
  import accbank_defs::*;

  typedef struct {
    logic [7:0] val;
    logic       c;
    logic       o;
  } exp_t;

  logic clk;
  logic clearN;
  int   n_checks;
  int   n_pass;
  exp_t sb[$];

  accumulator_bank_if #(.N(8), .NREG(4)) bus ();

  accumulator_bank #(.N(8), .NREG(4)) dut (
    .clk    (clk),
    .clearN (clearN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (clearN && bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(bus.regAOut), 32'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", 32'(bus.regAOut), 32'(e.val));
        chk("carry", 32'(bus.carry), 32'(e.c));
        chk("ovf", 32'(bus.ovf), 32'(e.o));
      end
    end
  end

  task automatic drive(input logic [2:0] op, input logic [1:0] sel, input logic [7:0] ir,
                       input logic [7:0] inp);
    bus.op     = op;
    bus.regSel = sel;
    bus.IROut  = ir;
    bus.Input  = inp;
    bus.start  = 1'b1;
  endtask

  task automatic single(input logic [2:0] op, input logic [1:0] sel, input logic [7:0] ir,
                        input logic [7:0] inp, input logic [7:0] ev, input logic ec,
                        input logic eo);
    exp_t e;
    drive(op, sel, ir, inp);
    if (op != OP_NOP) begin
      e.val = ev; e.c = ec; e.o = eo;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic mul(input logic [1:0] sel, input logic [7:0] ir, input logic [7:0] ev,
                     input logic ec, input logic intrude);
    exp_t e;
    int   cyc;
    int   nbusy;
    drive(OP_MUL, sel, ir, 8'h00);
    e.val = ev; e.c = ec; e.o = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc   = 1;
    nbusy = 0;
    while (!bus.done && cyc < 30) begin
      if (bus.busy) nbusy++;
      if (intrude && cyc == 2) begin
        drive(OP_LOAD_IN, 2'd3, 8'hFF, 8'h55);
        #1;
        chk("busy_read_port", 32'(bus.regAOut), 32'h3C);
      end
      if (intrude && cyc == 6) begin
        bus.start  = 1'b0;
        bus.regSel = sel;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("mul_done_latency", 32'(cyc), 32'd9);
    chk("mul_busy_cycles", 32'(nbusy), 32'd8);
    chk("busy_low_at_done", 32'(bus.busy), 32'd0);
    @(negedge clk); #1;
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    clearN     = 1'b0;
    bus.start  = 1'b0;
    bus.op     = OP_NOP;
    bus.regSel = '0;
    bus.IROut  = '0;
    bus.Input  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_aeq0", 32'(bus.Aeq0), 32'd1);
    chk("rst_apos", 32'(bus.Apos), 32'd1);
    @(negedge clk); #1;
    clearN = 1'b1;
    @(negedge clk); #1;

    // Reset in the middle of a multiply
    single(OP_LOAD_IN, 2'd2, 8'h00, 8'h0C, 8'h0C, 1'b0, 1'b0);
    drive(OP_MUL, 2'd2, 8'h0B, 8'h00);
    sb.push_back('{val: 8'h84, c: 1'b0, o: 1'b0});
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    clearN = 1'b0;
    #1;
    sb.delete();
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_carry", 32'(bus.carry), 32'd0);
    chk("abort_ovf", 32'(bus.ovf), 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus.regSel = 2'(i);
      #1;
      chk("abort_reg", 32'(bus.regAOut), 32'd0);
    end
    chk("abort_aeq0", 32'(bus.Aeq0), 32'd1);
    chk("abort_apos", 32'(bus.Apos), 32'd1);
    @(negedge clk); #1;
    clearN = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    bus.regSel = 2'd2;
    #1;
    chk("no_late_write", 32'(bus.regAOut), 32'd0);
    chk("no_late_busy", 32'(bus.busy), 32'd0);
    @(negedge clk); #1;

    // Signed overflow on ADD
    single(OP_LOAD_IN, 2'd1, 8'h00, 8'h7F, 8'h7F, 1'b0, 1'b0);
    single(OP_ADD, 2'd1, 8'h01, 8'h00, 8'h80, 1'b0, 1'b1);
    chk("add_apos", 32'(bus.Apos), 32'd0);

    // SUB to zero, then borrow; loads hold flags
    single(OP_LOAD_IR, 2'd0, 8'h05, 8'h00, 8'h05, 1'b0, 1'b1);
    single(OP_SUB, 2'd0, 8'h05, 8'h00, 8'h00, 1'b1, 1'b0);
    chk("sub_aeq0", 32'(bus.Aeq0), 32'd1);
    single(OP_SUB, 2'd0, 8'h01, 8'h00, 8'hFF, 1'b0, 1'b0);
    single(OP_ADD, 2'd0, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0);
    single(OP_SUB, 2'd1, 8'h01, 8'h00, 8'h7F, 1'b1, 1'b1);
    single(OP_NOP, 2'd1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("nop_no_done", 32'(bus.done), 32'd0);
    single(OP_CLR, 2'd1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);

    // Multiplies
    single(OP_LOAD_IR, 2'd2, 8'h0C, 8'h00, 8'h0C, 1'b1, 1'b1);
    mul(2'd2, 8'h0B, 8'h84, 1'b0, 1'b0);
    single(OP_LOAD_IR, 2'd2, 8'h20, 8'h00, 8'h20, 1'b0, 1'b0);
    mul(2'd2, 8'h10, 8'h00, 1'b1, 1'b0);
    chk("mul_aeq0", 32'(bus.Aeq0), 32'd1);

    // Start ignored while busy; read port follows regSel
    single(OP_LOAD_IN, 2'd3, 8'h00, 8'h3C, 8'h3C, 1'b1, 1'b0);
    single(OP_LOAD_IR, 2'd2, 8'h03, 8'h00, 8'h03, 1'b1, 1'b0);
    mul(2'd2, 8'h07, 8'h15, 1'b0, 1'b1);
    bus.regSel = 2'd3;
    #1;
    chk("reg3_untouched", 32'(bus.regAOut), 32'h3C);
    @(negedge clk); #1;

    // Arithmetic shift right
    single(OP_LOAD_IR, 2'd0, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0);
    single(OP_SHR, 2'd0, 8'h00, 8'h00, 8'hC0, 1'b1, 1'b0);
    chk("shr_apos", 32'(bus.Apos), 32'd0);
    single(OP_SHR, 2'd0, 8'h00, 8'h00, 8'hE0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
